change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream of the vending controller. Takes the change amount produced by the coin comparator and pays it out as a sequence of physical coin-eject pulses, largest coin (value 2) first, then value 1.
- Paces the eject mechanism with a ready input, fixed pulse width and fixed inter-coin gap.
- Reports busy, remaining amount, coins ejected and a completion strobe back to the controller.

Parameters:
- WIDTH, 4, bit width of amount, remaining and coin count.
- PULSE_CYCLES, 4, cycles each eject output is held high (>=1).
- GAP_CYCLES, 2, idle cycles after every eject pulse before the next coin is selected (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle request to start a payout; sampled only in IDLE.
- amount  input  WIDTH  change value to pay out, captured when load is accepted.
- mech_ready  input  1  eject mechanism can accept a coin; sampled in SELECT.
- eject2  output  1  drive value-2 coin ejector.
- eject1  output  1  drive value-1 coin ejector.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle strobe when a payout completes.
- remaining  output  WIDTH  change still owed.
- coins_out  output  WIDTH  coins ejected in the current or last payout; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, remaining=0, coins_out=0. All of eject2, eject1, busy and done are 0. A reset mid-payout aborts immediately and truncates any eject pulse.
- States: IDLE, SELECT, PULSE, GAP, DONE. All outputs are registered or decoded from registered state; no combinational input-to-output path.
- IDLE:
  - load=1 and amount>0: remaining<=amount, coins_out<=0, next state SELECT.
  - load=1 and amount=0: coins_out<=0, next state DONE.
  - load=0: stay in IDLE.
- SELECT:
  - mech_ready=0: stay in SELECT, no ejects asserted.
  - mech_ready=1: latch coin value (2 if remaining>=2, else 1), next state PULSE.
- PULSE:
  - Exactly one of eject2/eject1 is high, matching the latched coin, for PULSE_CYCLES cycles. mech_ready is ignored here.
  - On the final PULSE cycle's edge: remaining<=remaining-coin and coins_out<=coins_out+1 (saturating), next state GAP.
- GAP: ejects low for GAP_CYCLES cycles. Then go to SELECT if remaining>0, else DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. remaining (=0) and coins_out hold until the next accepted load.
- load is ignored in every state except IDLE; a load arriving in DONE is lost.
- amount is sampled only on the cycle load is accepted; later changes have no effect.
- Underflow is impossible by coin choice; remaining never wraps.
- Timing: load sampled at edge 0 (IDLE, amount>0) gives SELECT in cycle 1. If mech_ready=1, PULSE occupies cycles 2..1+PULSE_CYCLES.
- Per coin with mech_ready held high: 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Coin count for amount N: floor(N/2) value-2 coins plus (N mod 2) value-1 coins.

Test Plan:
- Reset/idle: rst low, then high, load never asserted -> all outputs 0, busy=0 indefinitely.
- Payout 5 (defaults, mech_ready=1), load at cycle 0 ->
  - eject2 high in cycles 2-5 and 9-12; eject1 high in cycles 16-19.
  - remaining reads 5, then 3 from cycle 6, 1 from cycle 13, 0 from cycle 20.
  - done high in cycle 22, coins_out=3, busy low from cycle 23.
- Zero change: load with amount=0 -> done in cycle 1, no eject, coins_out=0, IDLE in cycle 2.
- Backpressure: amount=2, mech_ready low cycles 0-9, high from cycle 10 -> SELECT held through cycle 10; eject2 high cycles 11-14; done in cycle 17.
- Ignored load: during a payout of 3, pulse load with amount=15 -> payout completes with two coins (2 then 1), remaining never shows 15.
- Reset mid-pulse: amount=6, drive rst low in cycle 3 -> eject2 drops asynchronously, all outputs 0. A later load of 1 performs a clean single value-1 payout.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount as a paced sequence of coin-eject
// pulses, value-2 coins first, then a final value-1 coin if the amount is odd.
// All outputs come straight from registers; nothing is combinational from inputs.
module change_dispenser #(
  parameter int WIDTH        = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] amount,
  input  logic             mech_ready,
  output logic             eject2,
  output logic             eject1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] coins_out
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            coin_two;

  // Payout sequencer: state, timing counter, coin choice and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      coin_two  <= 1'b0;
      eject2    <= 1'b0;
      eject1    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      coins_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            busy      <= 1'b1;
            coins_out <= '0;
            cnt       <= '0;
            if (amount != '0) begin
              remaining <= amount;
              state     <= SELECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SELECT: begin
          if (mech_ready) begin
            coin_two <= (remaining > WIDTH'(1));
            eject2   <= (remaining > WIDTH'(1));
            eject1   <= !(remaining > WIDTH'(1));
            cnt      <= '0;
            state    <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            eject2    <= 1'b0;
            eject1    <= 1'b0;
            remaining <= remaining - (coin_two ? WIDTH'(2) : WIDTH'(1));
            if (coins_out != '1) begin
              coins_out <= coins_out + WIDTH'(1);
            end
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (remaining != '0) begin
              state <= SELECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          eject2 <= 1'b0;
          eject1 <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payouts with a hand-built expected event list;
// a monitor turns eject pulses and done strobes into events and compares them.
module tb_change_dispenser;

  localparam int WIDTH = 4;
  localparam int P     = 4;
  localparam int G     = 2;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] amount;
  logic             mech_ready;
  logic             eject2;
  logic             eject1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] coins_out;

  // kind: 2 = value-2 pulse, 1 = value-1 pulse, 0 = done strobe.
  // Pulses: rem_a = remaining during pulse, rem_b = remaining after it.
  // Done:   rem_a = remaining, rem_b = coins_out.
  typedef struct {
    int kind;
    int cyc;
    int len;
    int rem_a;
    int rem_b;
  } ev_t;

  ev_t expq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  int  in_pulse = 0;
  int  p_kind   = 0;
  int  p_start  = 0;
  int  p_len    = 0;
  int  p_rem    = 0;

  change_dispenser #(.WIDTH(WIDTH), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .amount     (amount),
    .mech_ready (mech_ready),
    .eject2     (eject2),
    .eject1     (eject1),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .coins_out  (coins_out)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: cycle k of a payout is cyc == base + k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic popCompare(input ev_t got);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", got.kind, got.cyc);
    end else begin
      e = expq.pop_front();
      checkOutput($sformatf("event_kind@%0d", e.cyc), got.kind, e.kind);
      checkOutput($sformatf("event_cycle k%0d", e.kind), got.cyc, e.cyc);
      checkOutput($sformatf("event_len k%0d@%0d", e.kind, e.cyc), got.len, e.len);
      checkOutput($sformatf("event_rem_a k%0d@%0d", e.kind, e.cyc), got.rem_a, e.rem_a);
      checkOutput($sformatf("event_rem_b k%0d@%0d", e.kind, e.cyc), got.rem_b, e.rem_b);
    end
  endtask

  // Monitor: assembles eject pulses and done strobes into events mid-cycle.
  always @(negedge clk) begin
    ev_t g;
    int  now_kind;
    if (!rst) begin
      in_pulse = 0;
    end else begin
      checkOutput("eject_exclusive", int'(eject2 & eject1), 0);
      now_kind = eject2 ? 2 : (eject1 ? 1 : 0);
      if (in_pulse == 0) begin
        if (now_kind != 0) begin
          in_pulse = 1;
          p_kind   = now_kind;
          p_start  = cyc;
          p_len    = 1;
          p_rem    = int'(remaining);
        end
      end else if (now_kind == p_kind) begin
        p_len++;
      end else begin
        g.kind  = p_kind;
        g.cyc   = p_start;
        g.len   = p_len;
        g.rem_a = p_rem;
        g.rem_b = int'(remaining);
        popCompare(g);
        in_pulse = 0;
      end
      if (done) begin
        g.kind  = 0;
        g.cyc   = cyc;
        g.len   = 0;
        g.rem_a = int'(remaining);
        g.rem_b = int'(coins_out);
        popCompare(g);
      end
    end
  end

  // One payout: load at cycle 0, mech_ready high from ready_cycle, optional
  // extra load (amount 15) at spur_cycle; expected events come from a coin model.
  task automatic applyStimulus(input int amt, input int ready_cycle, input int spur_cycle);
    ev_t e;
    int  base;
    int  s;
    int  sel;
    int  rem;
    int  coin;
    int  n;
    int  k;
    @(negedge clk);
    base       = cyc;
    load       = 1'b1;
    amount     = WIDTH'(amt);
    mech_ready = (ready_cycle <= 0);
    rem = amt;
    s   = 1;
    n   = 0;
    while (rem > 0) begin
      sel     = (s < ready_cycle) ? ready_cycle : s;
      coin    = (rem >= 2) ? 2 : 1;
      e.kind  = coin;
      e.cyc   = base + sel + 1;
      e.len   = P;
      e.rem_a = rem;
      e.rem_b = rem - coin;
      expq.push_back(e);
      rem = rem - coin;
      n++;
      s = sel + 1 + P + G;
    end
    e.kind  = 0;
    e.cyc   = base + s;
    e.len   = 0;
    e.rem_a = 0;
    e.rem_b = n;
    expq.push_back(e);
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      load       = 1'b0;
      amount     = ~WIDTH'(amt);
      mech_ready = (k >= ready_cycle);
      if (busy == 1'b0) break;
      if (k == spur_cycle) begin
        load   = 1'b1;
        amount = WIDTH'(15);
      end
    end
    load = 1'b0;
    checkOutput($sformatf("idle_cycle amt%0d", amt), k, s + 1);
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    amount     = '0;
    mech_ready = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("in_reset", int'({eject2, eject1, busy, done, remaining, coins_out}), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", int'({eject2, eject1, busy, done, remaining, coins_out}), 0);
    end

    $display("[TB] payout 5");
    applyStimulus(5, 0, -1);
    $display("[TB] zero change");
    applyStimulus(0, 0, -1);
    $display("[TB] backpressure");
    applyStimulus(2, 10, -1);
    $display("[TB] ignored load during payout");
    applyStimulus(3, 0, 5);
    $display("[TB] load during done strobe");
    applyStimulus(1, 0, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stay_idle_after_done_load", int'(busy), 0);
    end
    $display("[TB] payout 15");
    applyStimulus(15, 0, -1);

    $display("[TB] reset mid-pulse");
    @(negedge clk);
    load       = 1'b1;
    amount     = WIDTH'(6);
    mech_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("eject2_before_reset", int'(eject2), 1);
    rst = 1'b0;
    #1 checkOutput("reset_abort", int'({eject2, eject1, busy, done, remaining, coins_out}), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(1, 0, -1);

    repeat (3) @(negedge clk);
    checkOutput("events_outstanding", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
